// File: rtl/hsci_txn_sequencer.sv
// Single-transaction HSCI sequencer: stages a command frame in BRAM, programs the
// master transfer registers, pulses run, polls done and returns one response.
module hsci_txn_sequencer #(
    parameter int                           REGMAP_ADDR_WIDTH = 16,
    parameter logic [14:0]                  BRAM_BASE         = 15'h0000,
    parameter logic [14:0]                  RD_RESULT_OFFSET  = 15'h0002,
    parameter logic [REGMAP_ADDR_WIDTH-1:0] REG_XFER_NUM      = REGMAP_ADDR_WIDTH'(16'h0004),
    parameter logic [REGMAP_ADDR_WIDTH-1:0] REG_BYTE_NUM      = REGMAP_ADDR_WIDTH'(16'h0008),
    parameter logic [REGMAP_ADDR_WIDTH-1:0] REG_ADDR_SIZE     = REGMAP_ADDR_WIDTH'(16'h000C),
    parameter logic [REGMAP_ADDR_WIDTH-1:0] REG_BRAM_START    = REGMAP_ADDR_WIDTH'(16'h0010),
    parameter logic [REGMAP_ADDR_WIDTH-1:0] REG_RUN           = REGMAP_ADDR_WIDTH'(16'h0014),
    parameter logic [REGMAP_ADDR_WIDTH-1:0] REG_STATUS        = REGMAP_ADDR_WIDTH'(16'h0018),
    parameter int                           DONE_BIT          = 0,
    parameter int                           POLL_HOLDOFF      = 32,
    parameter int                           TIMEOUT           = 65535
) (
    input  logic                         axi_clk,
    input  logic                         axi_resetn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_rnw,
    input  logic [31:0]                  req_addr,
    input  logic [31:0]                  req_wdata,
    input  logic [1:0]                   req_size,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_rdata,
    output logic                         rsp_err,
    output logic                         busy,
    output logic                         reg_wr_en,
    output logic [REGMAP_ADDR_WIDTH-1:0] reg_waddr,
    output logic [31:0]                  reg_wdata,
    output logic [REGMAP_ADDR_WIDTH-1:0] reg_raddr,
    input  logic [31:0]                  reg_rdata,
    output logic                         bram_we,
    output logic [14:0]                  bram_addr,
    output logic [31:0]                  bram_wdata,
    input  logic [31:0]                  bram_rdata
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LD_ADDR   = 4'd1;
    localparam logic [3:0] S_LD_DATA   = 4'd2;
    localparam logic [3:0] S_CFG_XFER  = 4'd3;
    localparam logic [3:0] S_CFG_BYTE  = 4'd4;
    localparam logic [3:0] S_CFG_ASIZE = 4'd5;
    localparam logic [3:0] S_CFG_BRAM  = 4'd6;
    localparam logic [3:0] S_RUN_SET   = 4'd7;
    localparam logic [3:0] S_RUN_CLR   = 4'd8;
    localparam logic [3:0] S_HOLDOFF   = 4'd9;
    localparam logic [3:0] S_POLL      = 4'd10;
    localparam logic [3:0] S_FETCH     = 4'd11;
    localparam logic [3:0] S_RESP      = 4'd12;

    // 15-bit sums wrap modulo 2^15, so BRAM_BASE=7FFF puts the data word at 0.
    localparam logic [14:0] BRAM_DATA_ADDR   = BRAM_BASE + 15'd1;
    localparam logic [14:0] BRAM_RESULT_ADDR = BRAM_BASE + RD_RESULT_OFFSET;
    localparam logic [15:0] HOLD_LAST        = (POLL_HOLDOFF > 0) ? 16'(POLL_HOLDOFF - 1) : 16'd0;
    localparam logic [15:0] TIMEOUT_W        = 16'(TIMEOUT);

    logic [3:0]  state_q, state_d;
    logic        rnw_q, rnw_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        phase_q, phase_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] poll_inc;
    logic        unused_reg_rdata;

    assign poll_inc         = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
    assign unused_reg_rdata = ^reg_rdata;

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q    <= S_IDLE;
            rnw_q      <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            size_q     <= 2'd0;
            cnt_q      <= 16'd0;
            poll_cnt_q <= 16'd0;
            phase_q    <= 1'b0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            cnt_q      <= cnt_d;
            poll_cnt_q <= poll_cnt_d;
            phase_q    <= phase_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        cnt_d      = cnt_q;
        poll_cnt_d = poll_cnt_q;
        phase_d    = phase_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rnw_d      = req_rnw;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    size_d     = req_size;
                    poll_cnt_d = 16'd0;
                    rdata_d    = 32'd0;
                    err_d      = 1'b0;
                    state_d    = S_LD_ADDR;
                end
            end
            S_LD_ADDR:   state_d = S_LD_DATA;
            S_LD_DATA:   state_d = S_CFG_XFER;
            S_CFG_XFER:  state_d = S_CFG_BYTE;
            S_CFG_BYTE:  state_d = S_CFG_ASIZE;
            S_CFG_ASIZE: state_d = S_CFG_BRAM;
            S_CFG_BRAM:  state_d = S_RUN_SET;
            S_RUN_SET:   state_d = S_RUN_CLR;
            S_RUN_CLR: begin
                cnt_d   = 16'd0;
                state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = 16'd0;
                    phase_d = 1'b0;
                    state_d = S_POLL;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_POLL: begin
                // phase 0 presents the status address, phase 1 sees its data
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (reg_rdata[DONE_BIT]) begin
                        cnt_d   = 16'd0;
                        state_d = rnw_q ? S_FETCH : S_RESP;
                    end else begin
                        poll_cnt_d = poll_inc;
                        if (poll_inc >= TIMEOUT_W) begin
                            err_d   = 1'b1;
                            state_d = S_RESP;
                        end
                    end
                end
            end
            S_FETCH: begin
                if (cnt_q == 16'd2) begin
                    rdata_d = bram_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        busy       = 1'b1;
        rsp_valid  = 1'b0;
        rsp_rdata  = 32'd0;
        rsp_err    = 1'b0;
        reg_wr_en  = 1'b0;
        reg_waddr  = '0;
        reg_wdata  = 32'd0;
        reg_raddr  = '0;
        bram_we    = 1'b0;
        bram_addr  = 15'd0;
        bram_wdata = 32'd0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_LD_ADDR: begin
                bram_we    = 1'b1;
                bram_addr  = BRAM_BASE;
                bram_wdata = addr_q;
            end
            S_LD_DATA: begin
                bram_we    = 1'b1;
                bram_addr  = BRAM_DATA_ADDR;
                bram_wdata = rnw_q ? 32'd0 : wdata_q;
            end
            S_CFG_XFER: begin
                reg_wr_en = 1'b1;
                reg_waddr = REG_XFER_NUM;
            end
            S_CFG_BYTE: begin
                reg_wr_en = 1'b1;
                reg_waddr = REG_BYTE_NUM;
                reg_wdata = {30'd0, size_q};
            end
            S_CFG_ASIZE: begin
                reg_wr_en = 1'b1;
                reg_waddr = REG_ADDR_SIZE;
                reg_wdata = 32'd3;
            end
            S_CFG_BRAM: begin
                // the master subtracts one, so the register takes the 1-based start
                reg_wr_en = 1'b1;
                reg_waddr = REG_BRAM_START;
                reg_wdata = {17'd0, BRAM_DATA_ADDR};
            end
            S_RUN_SET: begin
                reg_wr_en = 1'b1;
                reg_waddr = REG_RUN;
                reg_wdata = {30'd0, rnw_q, 1'b1};
            end
            S_RUN_CLR: begin
                reg_wr_en = 1'b1;
                reg_waddr = REG_RUN;
            end
            S_POLL:  reg_raddr = REG_STATUS;
            S_FETCH: bram_addr = BRAM_RESULT_ADDR;
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hsci_txn_sequencer.sv
// Bench for hsci_txn_sequencer: directed transactions against a small regmap/BRAM
// model; expected BRAM writes, register writes and responses go through queues.
module tb_hsci_txn_sequencer;

    localparam logic [15:0] R_XFER   = 16'h0004;
    localparam logic [15:0] R_BYTE   = 16'h0008;
    localparam logic [15:0] R_ASIZE  = 16'h000C;
    localparam logic [15:0] R_BSTART = 16'h0010;
    localparam logic [15:0] R_RUN    = 16'h0014;
    localparam logic [15:0] R_STATUS = 16'h0018;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance
    logic        req_valid, req_ready, req_rnw, rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] req_addr, req_wdata, rsp_rdata, reg_wdata, reg_rdata, bram_wdata, bram_rdata;
    logic [1:0]  req_size;
    logic        reg_wr_en, bram_we;
    logic [15:0] reg_waddr, reg_raddr;
    logic [14:0] bram_addr;
    // wrap instance (BRAM_BASE = 7FFF)
    logic        req_valid_w, req_ready_w, req_rnw_w, rsp_valid_w, rsp_ready_w, rsp_err_w, busy_w;
    logic [31:0] req_addr_w, req_wdata_w, rsp_rdata_w, reg_wdata_w, reg_rdata_w, bram_wdata_w, bram_rdata_w;
    logic [1:0]  req_size_w;
    logic        reg_wr_en_w, bram_we_w;
    logic [15:0] reg_waddr_w, reg_raddr_w;
    logic [14:0] bram_addr_w;

    hsci_txn_sequencer #(.POLL_HOLDOFF(32), .TIMEOUT(8)) u_dut (
        .axi_clk(clk), .axi_resetn(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .reg_wr_en(reg_wr_en), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata)
    );

    hsci_txn_sequencer #(.BRAM_BASE(15'h7FFF), .POLL_HOLDOFF(32), .TIMEOUT(8)) u_wrap (
        .axi_clk(clk), .axi_resetn(rst_n),
        .req_valid(req_valid_w), .req_ready(req_ready_w), .req_rnw(req_rnw_w),
        .req_addr(req_addr_w), .req_wdata(req_wdata_w), .req_size(req_size_w),
        .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready_w), .rsp_rdata(rsp_rdata_w),
        .rsp_err(rsp_err_w), .busy(busy_w),
        .reg_wr_en(reg_wr_en_w), .reg_waddr(reg_waddr_w), .reg_wdata(reg_wdata_w),
        .reg_raddr(reg_raddr_w), .reg_rdata(reg_rdata_w),
        .bram_we(bram_we_w), .bram_addr(bram_addr_w), .bram_wdata(bram_wdata_w),
        .bram_rdata(bram_rdata_w)
    );

    // Master model: on a run pulse it deposits hsci_result in BRAM[2] and sets
    // done on status poll number done_after (0 = never).
    logic [31:0] mem [0:32767];
    logic [31:0] rd_p1;
    int          status_cnt = 0;
    int          done_after;
    logic [31:0] hsci_result;

    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_wdata;
        if (reg_wr_en && reg_waddr == R_RUN && reg_wdata[0]) begin
            mem[15'd2] <= hsci_result;
            status_cnt <= 0;
        end else if (reg_raddr == R_STATUS) begin
            status_cnt <= status_cnt + 1;
        end
        rd_p1      <= mem[bram_addr];
        bram_rdata <= rd_p1;
        reg_rdata  <= {31'd0, (reg_raddr == R_STATUS) && (done_after != 0) &&
                              (status_cnt + 1 >= 2 * done_after - 1)};
    end

    always @(posedge clk) begin
        reg_rdata_w  <= {31'd0, reg_raddr_w == R_STATUS};
        bram_rdata_w <= 32'd0;
    end

    logic [46:0] exp_bram[$], exp_bram_w[$];
    logic [47:0] exp_reg[$], exp_reg_w[$];
    rsp_t        exp_rsp[$], exp_rsp_w[$];
    int          acc_cyc = 0, acc_cyc_w = 0;
    int          rsp_lat = 0, rsp_lat_w = 0;
    bit          rsp_seen = 0, rsp_seen_w = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", nm, act);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: got event/timeout, expected none", nm);
    endtask

    task automatic exp_txn(input bit w, input logic [14:0] a0, input logic [31:0] d0,
                           input logic [14:0] a1, input logic [31:0] d1,
                           input logic [31:0] byte_num, input logic [31:0] bstart,
                           input logic [31:0] run, input logic [31:0] rdata,
                           input logic err, input int lat);
        rsp_t rs;
        rs.rdata = rdata;
        rs.err   = err;
        rs.lat   = lat;
        if (w) begin
            exp_bram_w.push_back({a0, d0});
            exp_bram_w.push_back({a1, d1});
            exp_reg_w.push_back({R_XFER, 32'd0});
            exp_reg_w.push_back({R_BYTE, byte_num});
            exp_reg_w.push_back({R_ASIZE, 32'd3});
            exp_reg_w.push_back({R_BSTART, bstart});
            exp_reg_w.push_back({R_RUN, run});
            exp_reg_w.push_back({R_RUN, 32'd0});
            exp_rsp_w.push_back(rs);
        end else begin
            exp_bram.push_back({a0, d0});
            exp_bram.push_back({a1, d1});
            exp_reg.push_back({R_XFER, 32'd0});
            exp_reg.push_back({R_BYTE, byte_num});
            exp_reg.push_back({R_ASIZE, 32'd3});
            exp_reg.push_back({R_BSTART, bstart});
            exp_reg.push_back({R_RUN, run});
            exp_reg.push_back({R_RUN, 32'd0});
            exp_rsp.push_back(rs);
        end
    endtask

    // Monitor: pops expectations whenever either DUT presents a write or a response.
    initial begin
        logic [46:0] eb;
        logic [47:0] er;
        rsp_t        rs;
        forever begin
            @(negedge clk);
            if (rsp_valid && !rsp_seen) begin rsp_seen = 1; rsp_lat = cyc - acc_cyc; end
            if (rsp_valid_w && !rsp_seen_w) begin rsp_seen_w = 1; rsp_lat_w = cyc - acc_cyc_w; end
            if (bram_we) begin
                if (exp_bram.size() == 0) fail_now("bram_wr_unexpected");
                else begin eb = exp_bram.pop_front(); chk("bram_wr", 64'({bram_addr, bram_wdata}), 64'(eb)); end
            end
            if (reg_wr_en) begin
                if (exp_reg.size() == 0) fail_now("reg_wr_unexpected");
                else begin er = exp_reg.pop_front(); chk("reg_wr", 64'({reg_waddr, reg_wdata}), 64'(er)); end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_seen = 0;
                if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
                else begin
                    rs = exp_rsp.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(rs.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(rs.err));
                    chk("rsp_latency", 64'(rsp_lat), 64'(rs.lat));
                end
            end
            if (bram_we_w) begin
                if (exp_bram_w.size() == 0) fail_now("wrap_bram_wr_unexpected");
                else begin eb = exp_bram_w.pop_front(); chk("wrap_bram_wr", 64'({bram_addr_w, bram_wdata_w}), 64'(eb)); end
            end
            if (reg_wr_en_w) begin
                if (exp_reg_w.size() == 0) fail_now("wrap_reg_wr_unexpected");
                else begin er = exp_reg_w.pop_front(); chk("wrap_reg_wr", 64'({reg_waddr_w, reg_wdata_w}), 64'(er)); end
            end
            if (rsp_valid_w && rsp_ready_w) begin
                rsp_seen_w = 0;
                if (exp_rsp_w.size() == 0) fail_now("wrap_rsp_unexpected");
                else begin
                    rs = exp_rsp_w.pop_front();
                    chk("wrap_rsp_rdata", 64'(rsp_rdata_w), 64'(rs.rdata));
                    chk("wrap_rsp_err", 64'(rsp_err_w), 64'(rs.err));
                    chk("wrap_rsp_latency", 64'(rsp_lat_w), 64'(rs.lat));
                end
            end
        end
    end

    task automatic send(input bit w, input bit rnw, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] sz);
        int n;
        if (w) begin
            req_valid_w = 1'b1; req_rnw_w = rnw; req_addr_w = addr; req_wdata_w = wd; req_size_w = sz;
        end else begin
            req_valid = 1'b1; req_rnw = rnw; req_addr = addr; req_wdata = wd; req_size = sz;
        end
        n = 0;
        @(negedge clk);
        while (!(w ? req_ready_w : req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("accept_expired");
        @(posedge clk);
        #1;
        if (w) begin acc_cyc_w = cyc; req_valid_w = 1'b0; end
        else begin acc_cyc = cyc; req_valid = 1'b0; end
        $display("[TB] txn inst=%0d rnw=%0d addr=0x%0h wdata=0x%0h size=%0d", w, rnw, addr, wd, sz);
    endtask

    task automatic wait_rsp(input bit w);
        int n;
        n = 0;
        while ((w ? exp_rsp_w.size() : exp_rsp.size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            fail_now("rsp_wait_expired");
            if (w) exp_rsp_w.delete(); else exp_rsp.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = 0; req_rnw = 0; req_addr = 0; req_wdata = 0; req_size = 0; rsp_ready = 0;
        req_valid_w = 0; req_rnw_w = 0; req_addr_w = 0; req_wdata_w = 0; req_size_w = 0; rsp_ready_w = 1;
        done_after = 0;
        hsci_result = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_ctrl", 64'({busy, rsp_valid, rsp_err, reg_wr_en, bram_we}), 64'd0);
        chk("reset_data", 64'(|{rsp_rdata, reg_waddr, reg_wdata, reg_raddr, bram_addr, bram_wdata}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // write, done on first poll, rsp_ready already high
        rsp_ready = 1; done_after = 1;
        exp_txn(0, 15'h0000, 32'h0000_1234, 15'h0001, 32'hDEAD_BEEF, 32'd3, 32'd1, 32'd1, 32'd0, 1'b0, 42);
        send(0, 1'b0, 32'h0000_1234, 32'hDEAD_BEEF, 2'd3);
        wait_rsp(0);

        // read, done on third poll; data word must be zero for reads
        done_after = 3; hsci_result = 32'h0000_00A5;
        exp_txn(0, 15'h0000, 32'h0000_0042, 15'h0001, 32'd0, 32'd0, 32'd1, 32'd3, 32'h0000_00A5, 1'b0, 49);
        send(0, 1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 2'd0);
        wait_rsp(0);

        // read that times out after 8 polls: no FETCH, so the stale BRAM result is not returned
        done_after = 0; hsci_result = 32'h5A5A_5A5A;
        exp_txn(0, 15'h0000, 32'h0000_0077, 15'h0001, 32'd0, 32'd2, 32'd1, 32'd3, 32'd0, 1'b1, 56);
        send(0, 1'b1, 32'h0000_0077, 32'd0, 2'd2);
        wait_rsp(0);

        // response backpressure
        rsp_ready = 0; done_after = 1;
        exp_txn(0, 15'h0000, 32'h0000_0100, 15'h0001, 32'h1111_2222, 32'd1, 32'd1, 32'd1, 32'd0, 1'b0, 42);
        send(0, 1'b0, 32'h0000_0100, 32'h1111_2222, 2'd1);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk("bp_rsp_valid_reached", 64'(rsp_valid), 64'd1);
        repeat (20) begin
            @(negedge clk);
            chk("bp_hold", 64'({rsp_valid, rsp_err, req_ready, rsp_rdata}), 64'({1'b1, 1'b0, 1'b0, 32'd0}));
        end
        @(posedge clk);
        #1;
        rsp_ready = 1;
        @(posedge clk);
        #1;
        chk("bp_release_req_ready", 64'(req_ready), 64'd1);

        // asynchronous reset in the middle of polling
        done_after = 0;
        exp_bram.push_back({15'h0000, 32'h0000_0300});
        exp_bram.push_back({15'h0001, 32'h0000_0033});
        exp_reg.push_back({R_XFER, 32'd0});
        exp_reg.push_back({R_BYTE, 32'd3});
        exp_reg.push_back({R_ASIZE, 32'd3});
        exp_reg.push_back({R_BSTART, 32'd1});
        exp_reg.push_back({R_RUN, 32'd1});
        exp_reg.push_back({R_RUN, 32'd0});
        send(0, 1'b0, 32'h0000_0300, 32'h0000_0033, 2'd3);
        while (cyc < acc_cyc + 45) @(negedge clk);
        chk("midpoll_busy", 64'({busy, reg_raddr}), 64'({1'b1, R_STATUS}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midpoll_reset_ready", 64'({req_ready, busy, rsp_valid, rsp_err, reg_wr_en, bram_we}), 64'({1'b1, 5'd0}));
        chk("midpoll_reset_data", 64'(|{rsp_rdata, reg_waddr, reg_wdata, reg_raddr, bram_addr, bram_wdata}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midpoll_pending", 64'(exp_bram.size() + exp_reg.size() + exp_rsp.size()), 64'd0);
        @(posedge clk);
        #1;
        done_after = 1;
        exp_txn(0, 15'h0000, 32'h0000_0500, 15'h0001, 32'h0000_0077, 32'd1, 32'd1, 32'd1, 32'd0, 1'b0, 42);
        send(0, 1'b0, 32'h0000_0500, 32'h0000_0077, 2'd1);
        wait_rsp(0);

        // BRAM_BASE = 7FFF: data word wraps to address 0, BRAM_START written as 0
        exp_txn(1, 15'h7FFF, 32'h0000_0ABC, 15'h0000, 32'h0000_0055, 32'd2, 32'd0, 32'd1, 32'd0, 1'b0, 42);
        send(1, 1'b0, 32'h0000_0ABC, 32'h0000_0055, 2'd2);
        wait_rsp(1);

        repeat (5) @(posedge clk);
        chk("queues_drained", 64'(exp_bram.size() + exp_reg.size() + exp_rsp.size() +
                                  exp_bram_w.size() + exp_reg_w.size() + exp_rsp_w.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
